// File: rtl/mem_pkg.sv
// Shared definitions for the memory access unit: size encodings, FSM states, defaults.
package mem_pkg;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic {
    StIdle = 1'b0,
    StRmw  = 1'b1
  } state_e;

  function automatic logic is_misaligned(size_e size, logic [1:0] off);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = off[0];
      SZ_WORD: mis = |off;
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response bus between the MEM pipeline stage and the memory access unit.
interface mem_access_unit_if;

  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic [31:0] ld_data;
  logic        ld_valid;
  logic        misalign;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  stall, ld_data, ld_valid, misalign
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output stall, ld_data, ld_valid, misalign
  );

endinterface

// File: rtl/byte_lane_merge.sv
// Little-endian lane handling: inserts store lanes into a RAM word and extracts/extends load
// lanes from it.
module byte_lane_merge
  import mem_pkg::*;
(
  input  size_e       size,
  input  logic        is_signed,
  input  logic [1:0]  byte_off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] merged,
  output logic [31:0] ld_ext
);

  logic [31:0] shifted;

  always_comb begin
    merged  = rdata;
    shifted = rdata >> {byte_off, 3'b000};
    ld_ext  = rdata;
    case (size)
      SZ_BYTE: begin
        merged[{byte_off, 3'b000} +: 8] = wdata[7:0];
        ld_ext = {{24{is_signed & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        // Half accesses are aligned, so only byte_off[1] picks the lane pair.
        merged[{byte_off[1], 4'b0000} +: 16] = wdata[15:0];
        ld_ext = {{16{is_signed & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        merged = wdata;
        ld_ext = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: single-cycle loads and word stores, two-cycle read-modify-write
// for byte/half stores.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = mem_pkg::ADDR_W,
  parameter int unsigned DATA_W = mem_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              clr,
  mem_access_unit_if.slave  req,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_input,
  output logic              ram_str,
  output logic              ram_sel,
  output logic              ram_ld,
  input  logic [DATA_W-1:0] ram_data
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   merge_q, merge_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   ld_data_q, ld_data_d;
  logic                ld_valid_q, ld_valid_d;
  logic                misalign_q, misalign_d;

  size_e       size;
  logic        misal;
  logic [31:0] merged;
  logic [31:0] ld_ext;

  assign size  = size_e'(req.req_size);
  assign misal = is_misaligned(size, req.req_addr[1:0]);

  byte_lane_merge u_lane (
    .size      (size),
    .is_signed (req.req_signed),
    .byte_off  (req.req_addr[1:0]),
    .wdata     (req.req_wdata),
    .rdata     (ram_data),
    .merged    (merged),
    .ld_ext    (ld_ext)
  );

  always_comb begin
    state_d     = state_q;
    merge_d     = merge_q;
    addr_d      = addr_q;
    ld_data_d   = ld_data_q;
    ld_valid_d  = 1'b0;
    misalign_d  = 1'b0;
    req.stall   = 1'b0;
    ram_ld      = 1'b0;
    ram_str     = 1'b0;
    ram_input   = req.req_wdata;
    ram_address = req.req_addr[ADDR_W+1:2];
    unique case (state_q)
      StIdle: begin
        if (req.req_valid) begin
          if (misal) begin
            misalign_d = 1'b1;
          end else if (!req.req_we) begin
            ram_ld     = 1'b1;
            ld_data_d  = ld_ext;
            ld_valid_d = 1'b1;
          end else if (size == SZ_WORD) begin
            ram_str = 1'b1;
          end else begin
            ram_ld    = 1'b1;
            req.stall = 1'b1;
            merge_d   = merged;
            addr_d    = req.req_addr[ADDR_W+1:2];
            state_d   = StRmw;
          end
        end
      end
      StRmw: begin
        ram_address = addr_q;
        ram_input   = merge_q;
        ram_str     = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Reset suppresses every strobe, including an in-flight RMW write.
    if (clr) begin
      req.stall = 1'b0;
      ram_ld    = 1'b0;
      ram_str   = 1'b0;
    end
  end

  assign ram_sel      = ram_str;
  assign req.ld_data  = ld_data_q;
  assign req.ld_valid = ld_valid_q;
  assign req.misalign = misalign_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= StIdle;
      merge_q    <= '0;
      addr_q     <= '0;
      ld_data_q  <= '0;
      ld_valid_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      merge_q    <= merge_d;
      addr_q     <= addr_d;
      ld_data_q  <= ld_data_d;
      ld_valid_q <= ld_valid_d;
      misalign_q <= misalign_d;
    end
  end

  logic unused_addr;
  assign unused_addr = ^req.req_addr[31:ADDR_W+2];

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed transactions against a word-array model
// of memory, compared every cycle, plus literal pins.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic [9:0]  ram_address;
  logic [31:0] ram_input;
  logic        ram_str;
  logic        ram_sel;
  logic        ram_ld;
  logic [31:0] ram_data;

  mem_access_unit_if bus ();

  mem_access_unit dut (
    .clk         (clk),
    .clr         (clr),
    .req         (bus.slave),
    .ram_address (ram_address),
    .ram_input   (ram_input),
    .ram_str     (ram_str),
    .ram_sel     (ram_sel),
    .ram_ld      (ram_ld),
    .ram_data    (ram_data)
  );

  always #5 clk = ~clk;

  // RAM attached to the DUT
  logic [31:0] tb_ram [1024];
  assign ram_data = ram_ld ? tb_ram[ram_address] : 32'h0;
  always @(posedge clk) if (ram_str) tb_ram[ram_address] <= ram_input;

  // Reference memory contents as seen by the program
  logic [31:0] model_mem [1024];

  int n_checks = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  logic        e_stall, e_str, e_ld, e_ld_valid, e_mis, e_input_chk;
  logic [9:0]  e_addr;
  logic [31:0] e_input, e_ld_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg,
                                             input logic [31:0] a);
    int nb = nbytes(sz);
    logic [31:0] v = model_mem[a[11:2]] >> (8 * int'(a[1:0]));
    logic [31:0] m;
    if (nb < 4) begin
      m = (32'd1 << (8 * nb)) - 32'd1;
      v = v & m;
      if (sg && v[8*nb-1]) v = v | ~m;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_merge(input logic [1:0] sz, input logic [31:0] a,
                                              input logic [31:0] wd);
    logic [31:0] w = model_mem[a[11:2]];
    for (int i = 0; i < nbytes(sz); i++) w[8*(int'(a[1:0])+i) +: 8] = wd[8*i +: 8];
    return w;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", {31'b0, bus.stall}, {31'b0, e_stall});
      chk("ram_str", {31'b0, ram_str}, {31'b0, e_str});
      chk("ram_sel", {31'b0, ram_sel}, {31'b0, e_str});
      chk("ram_ld", {31'b0, ram_ld}, {31'b0, e_ld});
      chk("ram_address", {22'b0, ram_address}, {22'b0, e_addr});
      chk("ld_valid", {31'b0, bus.ld_valid}, {31'b0, e_ld_valid});
      chk("misalign", {31'b0, bus.misalign}, {31'b0, e_mis});
      chk("ld_data", bus.ld_data, e_ld_data);
      if (e_input_chk) chk("ram_input", ram_input, e_input);
    end
  end

  // One request, held for as many cycles as the unit needs. Called at posedge+1.
  task automatic op(input logic v, input logic we, input logic [1:0] sz, input logic sg,
                    input logic [31:0] a, input logic [31:0] wd, input bit abort);
    logic mis, sub;
    logic [31:0] mrg;
    mis = v && (sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00));
    sub = v && !mis && we && sz != 2'b10;
    bus.req_valid = v; bus.req_we = we; bus.req_size = sz; bus.req_signed = sg;
    bus.req_addr = a; bus.req_wdata = wd; clr = 1'b0;
    e_stall = sub;
    e_str = v && !mis && we && sz == 2'b10;
    e_ld = v && !mis && (!we || sz != 2'b10);
    e_addr = a[11:2];
    e_input = wd;
    e_input_chk = e_str;
    mrg = model_merge(sz, a, wd);
    @(posedge clk);
    e_ld_valid = v && !mis && !we;
    e_mis = mis;
    if (e_ld_valid) e_ld_data = model_load(sz, sg, a);
    if (e_str) model_mem[a[11:2]] = wd;
    #1;
    if (sub) begin
      clr = abort;
      e_stall = 1'b0;
      e_str = !abort;
      e_ld = 1'b0;
      e_input = mrg;
      e_input_chk = !abort;
      bus.req_valid = v ^ abort ^ abort;
      @(posedge clk);
      if (!abort) model_mem[a[11:2]] = mrg;
      else e_ld_data = 32'h0;
      e_ld_valid = 1'b0;
      e_mis = 1'b0;
      #1;
      clr = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      tb_ram[i] = 32'h0;
      model_mem[i] = 32'h0;
    end
    clr = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_signed = 1'b0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    e_stall = 0; e_str = 0; e_ld = 0; e_ld_valid = 0; e_mis = 0; e_input_chk = 0;
    e_addr = '0; e_input = '0; e_ld_data = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // Word store then load
    op(1, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0);
    op(1, 0, 2'b10, 1, 32'h10, 32'h0, 0);
    chk("w_load_data", bus.ld_data, 32'hDEADBEEF);
    chk("w_load_valid", {31'b0, bus.ld_valid}, 32'h1);

    // Byte RMW and immediate load of the merged word
    op(1, 1, 2'b00, 0, 32'h12, 32'h55, 0);
    chk("rmw_ram", tb_ram[4], 32'hDE55BEEF);
    op(1, 0, 2'b10, 0, 32'h10, 32'h0, 0);
    chk("rmw_load", bus.ld_data, 32'hDE55BEEF);

    op(1, 0, 2'b00, 1, 32'h13, 32'h0, 0);
    chk("lb_s", bus.ld_data, 32'hFFFFFFDE);
    op(1, 0, 2'b00, 0, 32'h13, 32'h0, 0);
    chk("lb_u", bus.ld_data, 32'h000000DE);
    op(1, 0, 2'b01, 1, 32'h12, 32'h0, 0);
    chk("lh_s", bus.ld_data, 32'hFFFFDE55);
    op(1, 0, 2'b01, 1, 32'h10, 32'h0, 0);
    op(0, 0, 2'b00, 0, 32'h44, 32'h0, 0);

    // Misaligned accesses
    op(1, 0, 2'b01, 1, 32'h11, 32'h0, 0);
    chk("mis_lh", {30'b0, bus.misalign, bus.ld_valid}, 32'h2);
    op(1, 1, 2'b10, 0, 32'h12, 32'h11111111, 0);
    chk("mis_sw", {31'b0, bus.misalign}, 32'h1);
    op(1, 0, 2'b11, 0, 32'h10, 32'h0, 0);
    chk("mis_rsvd", {31'b0, bus.misalign}, 32'h1);
    chk("mis_ram", tb_ram[4], 32'hDE55BEEF);

    // Aborted RMW
    op(1, 1, 2'b10, 0, 32'h20, 32'h12345678, 0);
    op(1, 1, 2'b01, 0, 32'h20, 32'h0000BEEF, 1);
    chk("abort_ram", tb_ram[8], 32'h12345678);
    op(1, 0, 2'b10, 0, 32'h20, 32'h0, 0);
    chk("abort_load", bus.ld_data, 32'h12345678);
    op(1, 1, 2'b01, 0, 32'h22, 32'h0000CAFE, 0);
    op(1, 0, 2'b10, 0, 32'h20, 32'h0, 0);
    chk("sh_hi_load", bus.ld_data, 32'hCAFE5678);

    // Top word and address wrap
    op(1, 1, 2'b10, 0, 32'hFFC, 32'hA5A5A5A5, 0);
    op(1, 1, 2'b10, 0, 32'h1000, 32'h01020304, 0);
    op(1, 0, 2'b10, 0, 32'h0, 32'h0, 0);
    chk("wrap_load", bus.ld_data, 32'h01020304);
    op(1, 0, 2'b10, 0, 32'hFFC, 32'h0, 0);
    chk("top_load", bus.ld_data, 32'hA5A5A5A5);
    op(1, 1, 2'b00, 0, 32'h1003, 32'h000000AB, 0);
    chk("wrap_sb", tb_ram[0], 32'hAB020304);
    op(0, 0, 2'b00, 0, 32'h0, 32'h0, 0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
